db15_scan_reader: RTL and testbench

DB15_SCAN_READER -- requirements
Module: db15_scan_reader

---
 rtl/db15_scan_reader.sv | 121 ++++++++++++
 tb/tb_db15_scan_reader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/db15_scan_reader.sv
// Scans a DB15 adapter's 32-bit shift chain and publishes two-frame-consensus joystick words.
// Outputs update on the clk after a frame's final HIGH tick; free-running scan with no backpressure.
module db15_scan_reader #(
  parameter int unsigned CLK_DIV    = 24,
  parameter int unsigned IDLE_TICKS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TICKS - 1);

  state_t      state, state_nxt;
  logic [7:0]  div_cnt;
  logic [7:0]  idle_cnt, idle_cnt_nxt;
  logic [4:0]  bit_idx, bit_idx_nxt;
  logic        tick;
  logic        capture;
  logic        frame_end;
  logic [31:0] frame, prev_frame;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= 8'd0;
    end else if (tick) begin
      div_cnt <= 8'd0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    bit_idx_nxt  = bit_idx;
    capture      = 1'b0;
    frame_end    = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (idle_cnt == IDLE_LAST) begin
            state_nxt    = S_LOAD;
            idle_cnt_nxt = 8'd0;
          end else begin
            idle_cnt_nxt = idle_cnt + 8'd1;
          end
        end
        S_LOAD: begin
          state_nxt   = S_LOW;
          bit_idx_nxt = 5'd0;
        end
        S_LOW: begin
          state_nxt = S_HIGH;
          capture   = 1'b1;
        end
        S_HIGH: begin
          if (bit_idx == 5'd31) begin
            state_nxt = S_IDLE;
            frame_end = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 5'd1;
            state_nxt   = S_LOW;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Pin drivers are decoded from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      idle_cnt <= 8'd0;
      bit_idx  <= 5'd0;
      JOY_CLK  <= 1'b0;
      JOY_LOAD <= 1'b1;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      JOY_CLK  <= (state_nxt == S_HIGH);
      JOY_LOAD <= (state_nxt != S_LOAD);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame      <= 32'd0;
      prev_frame <= 32'd0;
      joystick1  <= 16'd0;
      joystick2  <= 16'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (capture) begin
        frame[bit_idx] <= ~JOY_DATA;
      end
      // A word is published only when two consecutive frames agree.
      if (frame_end) begin
        prev_frame <= frame;
        if (frame == prev_frame) begin
          joystick1 <= frame[15:0];
          joystick2 <= frame[31:16];
        end
      end
    end
  end

endmodule

// File: tb/tb_db15_scan_reader.sv
// Bench for db15_scan_reader: adapter shift-chain model, expected-word scoreboard, pin timing monitor.
module tb_db15_scan_reader;

  localparam int DIV      = 24;
  localparam int PERIOD   = 3096;
  localparam int WATCHDOG = 3400;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        JOY_DATA;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_done;

  logic [31:0] pattern = 32'd0;
  logic        force_high = 1'b1;
  logic [31:0] sr = 32'hFFFF_FFFF;
  logic        m_clk_d = 1'b0;
  logic        done = 1'b0;

  logic [31:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc, load_cnt, edges, lo_run, hi_run, phase_bad, mid_bad;
  logic        clk_d;
  logic        rst_prev;
  logic [31:0] last_j;
  logic [31:0] e;

  always #5 clk = ~clk;

  db15_scan_reader #(.CLK_DIV(24), .IDLE_TICKS(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .JOY_DATA   (JOY_DATA),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_done (frame_done)
  );

  // Adapter: parallel load of active-low buttons, shift toward bit 0 on JOY_CLK rise.
  assign JOY_DATA = force_high | sr[0];

  always @(negedge clk) begin
    if (!JOY_LOAD) begin
      sr <= ~pattern;
    end else if (JOY_CLK && !m_clk_d) begin
      sr <= {1'b1, sr[31:1]};
    end
    m_clk_d <= JOY_CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic expect_frame(input logic [15:0] j1, input logic [15:0] j2);
    exp_q.push_back({j2, j1});
  endtask

  task automatic wait_frame();
    do @(negedge clk); while (!frame_done);
  endtask

  // Stimulus
  initial begin
    int n;
    logic prev;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;

    // Idle line: all released, prev register already zero
    repeat (3) expect_frame(16'h0000, 16'h0000);
    repeat (3) wait_frame();

    force_high = 1'b0;
    pattern = {16'h8001, 16'h0013};
    expect_frame(16'h0000, 16'h0000);
    wait_frame();
    expect_frame(16'h0013, 16'h8001);
    wait_frame();
    expect_frame(16'h0013, 16'h8001);
    wait_frame();

    // One glitched frame with bit 4 dropped, then steady again
    pattern = {16'h8001, 16'h0003};
    expect_frame(16'h0013, 16'h8001);
    wait_frame();
    pattern = {16'h8001, 16'h0013};
    expect_frame(16'h0013, 16'h8001);
    wait_frame();
    expect_frame(16'h0013, 16'h8001);
    wait_frame();

    // Abort: 18th rise of the frame is HIGH with index 17
    expect_frame(16'h0013, 16'h8001);
    n = 0;
    prev = 1'b0;
    while (n < 18) begin
      @(negedge clk);
      if (JOY_CLK && !prev) n++;
      prev = JOY_CLK;
    end
    #1 reset_n = 1'b0;
    exp_q.delete();
    pattern = {16'h0000, 16'h00F0};
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    expect_frame(16'h0000, 16'h0000);
    expect_frame(16'h00F0, 16'h0000);
    wait_frame();
    wait_frame();

    repeat (5) @(negedge clk);
    done = 1'b1;
  end

  // Monitor and scoreboard
  initial begin
    cyc = 0; load_cnt = 0; edges = 0; lo_run = 0; hi_run = 0;
    phase_bad = 0; mid_bad = 0; clk_d = 1'b0; rst_prev = 1'b1; last_j = 32'd0;
    @(posedge clk);
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        if (rst_prev) begin
          #1;
          chk("rst_joy_clk", {31'd0, JOY_CLK}, 32'd0);
          chk("rst_joy_load", {31'd0, JOY_LOAD}, 32'd1);
          chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
          chk("rst_joystick1", {16'd0, joystick1}, 32'd0);
          chk("rst_joystick2", {16'd0, joystick2}, 32'd0);
        end
        rst_prev = 1'b0;
        cyc = 0; load_cnt = 0; edges = 0; lo_run = 0; hi_run = 0;
        phase_bad = 0; mid_bad = 0; clk_d = 1'b0; last_j = 32'd0;
      end else begin
        rst_prev = 1'b1;
        cyc++;
        if (!JOY_LOAD) load_cnt++;
        if (JOY_CLK && !clk_d) begin
          if (edges != 0 && lo_run != DIV) phase_bad++;
          lo_run = 0;
          edges++;
        end
        if (!JOY_CLK && clk_d) begin
          if (hi_run != DIV) phase_bad++;
          hi_run = 0;
        end
        if (JOY_CLK) hi_run++;
        else lo_run++;
        clk_d = JOY_CLK;
        if ({joystick2, joystick1} != last_j && !frame_done) mid_bad++;
        last_j = {joystick2, joystick1};

        if (frame_done) begin
          chk("frame_period", 32'(cyc), 32'(PERIOD));
          chk("load_low_cycles", 32'(load_cnt), 32'(DIV));
          chk("rising_edges", 32'(edges), 32'd32);
          chk("clk_phase_len_errs", 32'(phase_bad), 32'd0);
          chk("mid_frame_changes", 32'(mid_bad), 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("joystick1", {16'd0, joystick1}, {16'd0, e[15:0]});
            chk("joystick2", {16'd0, joystick2}, {16'd0, e[31:16]});
          end
          cyc = 0; load_cnt = 0; edges = 0; phase_bad = 0; mid_bad = 0;
        end

        if (cyc > WATCHDOG) begin
          checks++;
          failures++;
          $display("FAIL watchdog: no frame_done for %0d cycles, expected one every %0d", cyc, PERIOD);
          $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
          $fatal(1, "watchdog expired");
        end

        if (done) begin
          chk("frames_outstanding", 32'(exp_q.size()), 32'd0);
          $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
          $finish;
        end
      end
    end
  end

endmodule
